// File: rtl/bin_to_bcd_converter_pkg.sv
// Shared types and constants for the shift-and-add-3 binary-to-BCD converter.
package bin_to_bcd_pkg;

    // Converter control states.
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    // Width of one packed BCD digit.
    localparam int unsigned BCD_DIGIT_W = 4;

    // A digit at or above this value is corrected before the next shift.
    localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd5;

    // Correction added so that doubling carries into the next digit.
    localparam logic [BCD_DIGIT_W-1:0] ADJ_ADD = 4'd3;

endpackage

// File: rtl/bin_to_bcd_converter_if.sv
// Request/result bundle between a converter user (master) and the converter (slave).
interface bin_to_bcd_converter_if
    import bin_to_bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 16,
    parameter int unsigned DIGITS = 5
);

    logic                          start;
    logic [BIN_W-1:0]              bin;
    logic                          busy;
    logic                          done;
    logic [BCD_DIGIT_W*DIGITS-1:0] bcd;
    logic                          overflow;

    // Requester side: issues start/bin, observes status and result.
    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd,
        input  overflow
    );

    // Converter side: accepts start/bin, drives status and result.
    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd,
        output overflow
    );

endinterface

// File: rtl/bin_to_bcd_converter_digit_adjust.sv
// One-digit add-3 correction applied before each double-dabble shift.
module bcd_digit_adjust
    import bin_to_bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    // Digits 5..9 become 8..12, so the following shift carries out cleanly.
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= ADJ_THRESH) begin
            o_digit = i_digit + ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential binary-to-BCD converter, one double-dabble iteration per clock.
module bin_to_bcd_converter
    import bin_to_bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    bin_to_bcd_converter_if.slave bus
);

    localparam int unsigned BCD_W    = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W    = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [BIN_W-1:0] r_bin_shift;
    logic [BIN_W-1:0] w_bin_shift_next;
    logic [BCD_W-1:0] r_bcd_work;
    logic [BCD_W-1:0] w_bcd_work_next;
    logic [BCD_W-1:0] w_bcd_adj;
    logic             r_ovf_work;
    logic             w_ovf_work_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [BCD_W-1:0] r_bcd;
    logic             r_overflow;
    logic             r_done;

    // All digits are corrected in parallel from the current working register.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .i_digit (r_bcd_work[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (w_bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // State, working registers and iteration counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_bin_shift <= '0;
            r_bcd_work  <= '0;
            r_ovf_work  <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_next;
            r_bin_shift <= w_bin_shift_next;
            r_bcd_work  <= w_bcd_work_next;
            r_ovf_work  <= w_ovf_work_next;
            r_cnt       <= w_cnt_next;
        end
    end

    // Next-state and datapath: capture in IDLE, adjust-then-shift in SHIFT.
    always_comb begin
        w_state_next     = r_state;
        w_bin_shift_next = r_bin_shift;
        w_bcd_work_next  = r_bcd_work;
        w_ovf_work_next  = r_ovf_work;
        w_cnt_next       = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_bin_shift_next = bus.bin;
                    w_bcd_work_next  = '0;
                    w_ovf_work_next  = 1'b0;
                    w_cnt_next       = CNT_INIT;
                    w_state_next     = SHIFT;
                end
            end
            SHIFT: begin
                // {bcd_work, bin_shift} << 1; the bit leaving the top digit is sticky.
                w_bcd_work_next  = {w_bcd_adj[BCD_W-2:0], r_bin_shift[BIN_W-1]};
                w_bin_shift_next = r_bin_shift << 1;
                w_ovf_work_next  = r_ovf_work | w_bcd_adj[BCD_W-1];
                w_cnt_next       = r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    w_state_next = FINISH;
                end
            end
            FINISH: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Result registers only change on completion, so no partial value is ever visible.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bcd      <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == FINISH);
            if (r_state == FINISH) begin
                r_bcd      <= r_bcd_work;
                r_overflow <= r_ovf_work;
            end
        end
    end

    assign bus.busy     = (r_state != IDLE);
    assign bus.done     = r_done;
    assign bus.bcd      = r_bcd;
    assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Scoreboard bench: drivers push expected results, monitors pop on each done pulse.
module tb_bin_to_bcd_converter;

    logic clock = 1'b0;
    logic rst5;
    logic rst4;

    always #5 clock = ~clock;

    bin_to_bcd_converter_if #(.BIN_W(16), .DIGITS(5)) if5 ();
    bin_to_bcd_converter_if #(.BIN_W(16), .DIGITS(4)) if4 ();

    bin_to_bcd_converter #(.BIN_W(16), .DIGITS(5)) dut5 (
        .clock (clock),
        .reset (rst5),
        .bus   (if5.slave)
    );

    bin_to_bcd_converter #(.BIN_W(16), .DIGITS(4)) dut4 (
        .clock (clock),
        .reset (rst4),
        .bus   (if4.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [32:0] q5[$];
    logic [32:0] q4[$];
    logic [32:0] e5;
    logic [32:0] e4;

    // Decimal reference: bit 32 = overflow, digit i in bits [4i+3:4i].
    function automatic logic [32:0] ref_conv(input longint unsigned v, input int nd);
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < nd; i++) begin
            b[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return {(v != 0), b};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor for the 5-digit instance.
    always @(negedge clock) begin
        if (if5.done === 1'b1) begin
            n_tests++;
            if (q5.size() == 0) begin
                n_fail++;
                $display("FAIL dut5 unexpected done: got bcd=%h ovf=%b expected no done",
                         if5.bcd, if5.overflow);
            end else begin
                e5 = q5.pop_front();
                if ({if5.overflow, if5.bcd} !== {e5[32], e5[19:0]}) begin
                    n_fail++;
                    $display("FAIL dut5 result: got bcd=%h ovf=%b expected bcd=%h ovf=%b",
                             if5.bcd, if5.overflow, e5[19:0], e5[32]);
                end
            end
        end
    end

    // Monitor for the 4-digit instance.
    always @(negedge clock) begin
        if (if4.done === 1'b1) begin
            n_tests++;
            if (q4.size() == 0) begin
                n_fail++;
                $display("FAIL dut4 unexpected done: got bcd=%h ovf=%b expected no done",
                         if4.bcd, if4.overflow);
            end else begin
                e4 = q4.pop_front();
                if ({if4.overflow, if4.bcd} !== {e4[32], e4[15:0]}) begin
                    n_fail++;
                    $display("FAIL dut4 result: got bcd=%h ovf=%b expected bcd=%h ovf=%b",
                             if4.bcd, if4.overflow, e4[15:0], e4[32]);
                end
            end
        end
    end

    // Request a conversion on dut5; bin is scrambled right after capture.
    task automatic start5(input logic [15:0] v, input bit push);
        if5.start = 1'b1;
        if5.bin   = v;
        if (push) q5.push_back(ref_conv(64'(v), 5));
        @(posedge clock);
        #1;
        if5.start = 1'b0;
        if5.bin   = 16'($urandom);
    endtask

    // Wait for done on dut5, counting busy cycles; optionally pulse start mid-flight.
    task automatic wait5(output int lat, output int bcnt, input bit extra);
        lat  = 0;
        bcnt = 0;
        @(negedge clock);
        while (if5.done !== 1'b1 && lat < 40) begin
            if (if5.busy === 1'b1) bcnt++;
            if5.start = extra && (lat == 3 || lat == 10);
            lat++;
            @(negedge clock);
        end
        if5.start = 1'b0;
    endtask

    // Full conversion on dut4 with latency check.
    task automatic conv4(input logic [15:0] v);
        int n;
        n = 0;
        if4.start = 1'b1;
        if4.bin   = v;
        q4.push_back(ref_conv(64'(v), 4));
        @(posedge clock);
        #1;
        if4.start = 1'b0;
        if4.bin   = 16'($urandom);
        @(negedge clock);
        while (if4.done !== 1'b1 && n < 40) begin
            n++;
            @(negedge clock);
        end
        check("dut4 latency", 64'(n), 64'd17);
    endtask

    initial begin
        int lat;
        int bc;
        int dn;
        logic [15:0] v;

        rst5 = 1'b1;
        rst4 = 1'b1;
        if5.start = 1'b0;
        if5.bin   = '0;
        if4.start = 1'b0;
        if4.bin   = '0;
        repeat (3) @(negedge clock);
        check("reset busy", 64'(if5.busy), 64'd0);
        check("reset done", 64'(if5.done), 64'd0);
        check("reset bcd", 64'(if5.bcd), 64'd0);
        check("reset ovf", 64'(if5.overflow), 64'd0);
        check("reset dut4 bcd", 64'(if4.bcd), 64'd0);
        rst5 = 1'b0;
        rst4 = 1'b0;
        @(negedge clock);

        // Zero, then maximum input with timing checks.
        start5(16'd0, 1'b1);
        wait5(lat, bc, 1'b0);
        check("zero latency", 64'(lat), 64'd17);
        check("zero busy during done", 64'(if5.busy), 64'd0);
        start5(16'd65535, 1'b1);
        wait5(lat, bc, 1'b0);
        check("max latency", 64'(lat), 64'd17);
        check("max busy cycles", 64'(bc), 64'd17);
        check("max busy during done", 64'(if5.busy), 64'd0);

        // Back-to-back: second start issued in the done cycle.
        start5(16'd9, 1'b1);
        wait5(lat, bc, 1'b0);
        start5(16'd10, 1'b1);
        wait5(lat, bc, 1'b0);
        check("back-to-back latency", 64'(lat), 64'd17);

        // Extra starts while busy are ignored.
        start5(16'd1234, 1'b1);
        wait5(lat, bc, 1'b1);
        check("ignored-start latency", 64'(lat), 64'd17);
        repeat (25) @(negedge clock);
        check("ignored-start queue empty", 64'(q5.size()), 64'd0);

        // Reset mid-conversion aborts with no done.
        start5(16'd500, 1'b0);
        repeat (7) @(negedge clock);
        rst5 = 1'b1;
        #1;
        check("abort busy", 64'(if5.busy), 64'd0);
        check("abort bcd", 64'(if5.bcd), 64'd0);
        @(negedge clock);
        rst5 = 1'b0;
        dn = 0;
        repeat (30) begin
            @(negedge clock);
            if (if5.done === 1'b1) dn++;
        end
        check("abort no done", 64'(dn), 64'd0);
        check("abort bcd held", 64'(if5.bcd), 64'd0);
        start5(16'd42, 1'b1);
        wait5(lat, bc, 1'b0);
        check("post-abort latency", 64'(lat), 64'd17);

        // Randomized values across magnitudes.
        for (int i = 0; i < 20; i++) begin
            case (i % 3)
                0:       v = 16'($urandom_range(0, 99));
                1:       v = 16'($urandom_range(100, 9999));
                default: v = 16'($urandom);
            endcase
            start5(v, 1'b1);
            wait5(lat, bc, 1'b0);
            check("random latency", 64'(lat), 64'd17);
        end

        // Four-digit instance: overflow boundary then random.
        @(negedge clock);
        conv4(16'd12345);
        conv4(16'd9999);
        conv4(16'd10000);
        conv4(16'd0);
        conv4(16'd65535);
        for (int i = 0; i < 15; i++) begin
            conv4(16'($urandom));
        end

        repeat (5) @(negedge clock);
        check("final q5 empty", 64'(q5.size()), 64'd0);
        check("final q4 empty", 64'(q4.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_converter.md
Name: bin_to_bcd_converter

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method. It takes a binary count, such as a press counter or cycle count, and produces packed BCD digits for the per-digit seven-segment decoders on the HEX displays. It is the producer side of the 4-bit BCD digit interface and uses a start/busy/done handshake with one iteration per clock.

Parameters:
BIN_W, 16, width of binary input; legal range 1..32
DIGITS, 5, number of BCD output digits; output width 4*DIGITS

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  request conversion; sampled only in IDLE
bin  input  BIN_W  binary value; captured on the edge that accepts start
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse; bcd/overflow valid and updated
bcd  output  4*DIGITS  packed BCD; digit 0 (least significant) in bcd[3:0]
overflow  output  1  bin exceeded 10^DIGITS-1; registered with bcd

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - busy=0, done=0, overflow=0, bcd=0.
  - Internal shift register and iteration counter are cleared.
- States, encoded as an enum in the package:
  - IDLE: wait for start.
  - SHIFT: run BIN_W iterations.
  - FINISH: load the outputs.
- IDLE:
  - If start=1 at an edge, capture bin into the binary shift register, clear the BCD working register, set the iteration counter to BIN_W, and go to SHIFT.
  - If start=0, stay in IDLE.
- SHIFT, one iteration per cycle:
  - Every 4-bit working digit >=5 gets +3, all digits in parallel.
  - Then the concatenation {bcd_work, bin_shift} shifts left by 1.
  - The bit leaving the top digit ORs into a sticky overflow_work flag.
  - The counter decrements.
  - When the counter reaches 0 after the shift, go to FINISH.
- FINISH:
  - On the next edge, bcd<=bcd_work, overflow<=overflow_work, and done<=1 for exactly one cycle.
  - State returns to IDLE.
- Latency: if start is sampled at edge k, done is high in the cycle after edge k+BIN_W+1.
- busy timing:
  - busy=1 from edge k+1 through the edge that raises done.
  - busy=0 while done=1.
- Outputs bcd and overflow hold their value until the next done. They never show intermediate values.
- start while busy (SHIFT/FINISH) is ignored, with no queuing.
- start high in the done cycle is accepted; state is IDLE, so back-to-back conversions are legal.
- bin changes after capture have no effect on an in-flight conversion.
- Overflow: lower digits still hold (bin mod 10^DIGITS), because carries only propagate upward.
- Add-3 arithmetic is 4-bit per digit. An adjusted digit never exceeds 12 before the shift, so there is no intra-digit overflow.
- Reset mid-conversion aborts immediately:
  - No done pulse is produced.
  - bcd returns to 0.
  - The next start after reset deasserts behaves normally.
- The iteration counter is $clog2(BIN_W+1) bits wide.

Decomposition:
- Package bin_to_bcd_pkg holds:
  - The state enum {IDLE, SHIFT, FINISH}.
  - Constant BCD_DIGIT_W=4.
  - Constant ADJ_THRESH=5.
  - Constant ADJ_ADD=3.
- Sub-module bcd_digit_adjust: combinational, one 4-bit digit in, adjusted digit out. Instantiated DIGITS times via generate.
- Top module holds the FSM, shift registers, counter and output registers.

Test Plan:
- Reset then start with bin=0 (BIN_W=16, DIGITS=5) -> done at cycle 17 after start; bcd=20'h00000, overflow=0.
- bin=16'd65535 -> bcd=20'h65535, overflow=0; busy high for exactly 17 cycles, then low during the done cycle.
- bin=9, then start asserted in the done cycle with bin=10 -> first done bcd=20'h00009; second done 17 cycles later with bcd=20'h00010.
- start pulsed again at cycles 3 and 10 of a conversion of bin=1234 -> single done, bcd=20'h01234; extra starts ignored.
- Reset asserted at cycle 8 of a conversion of bin=500 -> busy=0, done never pulses, bcd=0. A new start with bin=42 then yields bcd=20'h00042.
- DIGITS=4, bin=12345 -> overflow=1, bcd=16'h2345. With bin=9999 -> overflow=0, bcd=16'h9999.
